// File: rtl/wen_data_merger.sv
// wen_data_merger: merges per-channel write strobes/data into one valid/ready stream.
// Each channel feeds a small FIFO. A round-robin arbiter picks which FIFO loads the
// registered output stage. Writes into a full FIFO are dropped and latch a sticky
// per-channel overflow flag.
module wen_data_merger #(
    parameter int unsigned NCH   = 3,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NCH-1:0]                       wen,
    input  logic [NCH*DW-1:0]                    i_data,
    input  logic                                 freeze,
    input  logic                                 o_ready,
    output logic                                 o_valid,
    output logic [DW-1:0]                        o_data,
    output logic [$clog2(NCH)-1:0]               o_ch,
    output logic [NCH-1:0]                       ovf,
    input  logic                                 ovf_clr,
    output logic [NCH*($clog2(DEPTH)+1)-1:0]     fill
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam int unsigned CW = $clog2(NCH);

    logic [DW-1:0] mem    [NCH][DEPTH];
    logic [AW-1:0] wptr_q [NCH];
    logic [AW-1:0] rptr_q [NCH];
    logic [FW-1:0] cnt_q  [NCH];
    logic [CW-1:0] rr_q;

    logic [NCH-1:0] nonempty;
    logic [NCH-1:0] full;
    logic [NCH-1:0] pop;
    logic [NCH-1:0] push_ok;
    logic [NCH-1:0] push_drop;
    logic [CW-1:0]  grant;
    logic           grant_valid;
    logic           load;
    logic [DW-1:0]  head;

    for (genvar g = 0; g < NCH; g++) begin : g_fill
        assign fill[g*FW +: FW] = cnt_q[g];
    end

    // Round-robin search for the first non-empty FIFO starting at the rr pointer.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= int'(NCH)) begin
                idx = idx - int'(NCH);
            end
            if (!grant_valid && nonempty[CW'(idx)]) begin
                grant_valid = 1'b1;
                grant       = CW'(idx);
            end
        end
    end

    // Per-channel status, pop/push decisions and the output-stage load condition.
    always_comb begin
        load = (!o_valid || o_ready) && !freeze && grant_valid;
        head = mem[grant][rptr_q[grant]];
        for (int n = 0; n < NCH; n++) begin
            nonempty[n]  = (cnt_q[n] != '0);
            full[n]      = (cnt_q[n] == FW'(DEPTH));
            pop[n]       = load && (grant == CW'(n));
            // A full FIFO being popped this edge frees its slot for the incoming word.
            push_ok[n]   = wen[n] && (!full[n] || pop[n]);
            push_drop[n] = wen[n] && full[n] && !pop[n];
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NCH; n++) begin
            if (push_ok[n]) begin
                mem[n][wptr_q[n]] <= i_data[n*DW +: DW];
            end
        end
    end

    // FIFO pointers, occupancy, overflow flags, arbiter pointer and output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < NCH; n++) begin
                wptr_q[n] <= '0;
                rptr_q[n] <= '0;
                cnt_q[n]  <= '0;
            end
            ovf     <= '0;
            rr_q    <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ch    <= '0;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (push_ok[n]) begin
                    wptr_q[n] <= wptr_q[n] + AW'(1);
                end
                if (pop[n]) begin
                    rptr_q[n] <= rptr_q[n] + AW'(1);
                end
                if (push_ok[n] && !pop[n]) begin
                    cnt_q[n] <= cnt_q[n] + FW'(1);
                end else if (!push_ok[n] && pop[n]) begin
                    cnt_q[n] <= cnt_q[n] - FW'(1);
                end
                // A new overflow beats a simultaneous clear.
                if (push_drop[n]) begin
                    ovf[n] <= 1'b1;
                end else if (ovf_clr) begin
                    ovf[n] <= 1'b0;
                end
            end

            if (load) begin
                o_valid <= 1'b1;
                o_data  <= head;
                o_ch    <= grant;
                rr_q    <= (grant == CW'(NCH - 1)) ? '0 : grant + CW'(1);
            end else if (o_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wen_data_merger.sv
// Directed bench for wen_data_merger; expected words are queued at push time and
// compared whenever the DUT completes an output handshake.
module tb_wen_data_merger;

    localparam int NCH   = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int FW    = 3;
    localparam int CW    = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NCH-1:0]    wen;
    logic [NCH*DW-1:0] i_data;
    logic              freeze;
    logic              o_ready;
    logic              o_valid;
    logic [DW-1:0]     o_data;
    logic [CW-1:0]     o_ch;
    logic [NCH-1:0]    ovf;
    logic              ovf_clr;
    logic [NCH*FW-1:0] fill;

    logic [15:0] sb[$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wen_data_merger #(
        .NCH   (NCH),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wen     (wen),
        .i_data  (i_data),
        .freeze  (freeze),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_ch    (o_ch),
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
        .fill    (fill)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fill_of(input int n);
        return 32'(fill[n*FW +: FW]);
    endfunction

    task automatic set_data(input int ch, input logic [7:0] val);
        i_data[ch*DW +: DW] = val;
    endtask

    task automatic expect_word(input int ch, input logic [7:0] val);
        sb.push_back({8'(ch), val});
    endtask

    // Compare any handshake about to complete, then advance to 1 time unit past the edge.
    task automatic step();
        logic [15:0] e;
        if (o_valid === 1'b1 && o_ready === 1'b1) begin
            n_checks++;
            assert (sb.size() > 0) else begin
                n_errors++;
                $error("FAIL unexpected_word: observed ch=%0d data=%0h expected no word",
                       o_ch, o_data);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out_data", 32'(o_data), 32'(e[7:0]));
                check("out_ch", 32'(o_ch), 32'(e[15:8]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wen     = '0;
        freeze  = 1'b0;
        ovf_clr = 1'b0;
        o_ready = 1'b0;
        sb.delete();
        #1;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        wen     = '0;
        i_data  = '0;
        freeze  = 1'b0;
        o_ready = 1'b0;
        ovf_clr = 1'b0;
        #1;
        step();
        step();
        check("rst_valid", 32'(o_valid), 0);
        check("rst_data", 32'(o_data), 0);
        check("rst_ch", 32'(o_ch), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_fill", 32'(fill), 0);
        reset_n = 1'b1;
        step();

        // Single word through an idle block: visible one edge after the push edge.
        o_ready = 1'b1;
        wen = 3'b010;
        set_data(1, 8'hA5);
        expect_word(1, 8'hA5);
        step();
        wen = '0;
        check("t1_no_bypass", 32'(o_valid), 0);
        check("t1_fill1", fill_of(1), 1);
        step();
        check("t1_valid", 32'(o_valid), 1);
        check("t1_data", 32'(o_data), 32'hA5);
        check("t1_ch", 32'(o_ch), 1);
        step();
        check("t1_idle", 32'(o_valid), 0);

        // All three channels at once: round-robin from pointer 0.
        do_reset();
        o_ready = 1'b1;
        wen = 3'b111;
        set_data(0, 8'h11);
        set_data(1, 8'h22);
        set_data(2, 8'h33);
        expect_word(0, 8'h11);
        expect_word(1, 8'h22);
        expect_word(2, 8'h33);
        step();
        wen = '0;
        check("t2_fill", 32'(fill), 32'h049);
        step();
        check("t2_v0", 32'(o_valid), 1);
        step();
        check("t2_v1", 32'(o_valid), 1);
        step();
        check("t2_v2", 32'(o_valid), 1);
        step();
        check("t2_idle", 32'(o_valid), 0);
        check("t2_drained", 32'(sb.size()), 0);

        // Overflow on ch0 while output is stalled.
        do_reset();
        o_ready = 1'b0;
        wen = 3'b001;
        for (int i = 0; i < 6; i++) begin
            set_data(0, 8'(i));
            if (i < 5) expect_word(0, 8'(i));
            step();
        end
        wen = '0;
        check("t3_fill0", fill_of(0), 4);
        check("t3_ovf", 32'(ovf), 1);
        check("t3_hold_valid", 32'(o_valid), 1);
        check("t3_hold_data", 32'(o_data), 0);
        o_ready = 1'b1;
        repeat (6) step();
        check("t3_idle", 32'(o_valid), 0);
        check("t3_fill0_empty", fill_of(0), 0);
        check("t3_ovf_sticky", 32'(ovf), 1);
        check("t3_drained", 32'(sb.size()), 0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t3_ovf_clr", 32'(ovf), 0);

        // Overflow and clear on the same edge, then push into a full FIFO being popped.
        o_ready = 1'b0;
        wen = 3'b010;
        for (int i = 0; i < 6; i++) begin
            set_data(1, 8'(8'h40 + i));
            if (i < 5) expect_word(1, 8'(8'h40 + i));
            ovf_clr = (i == 5);
            step();
        end
        ovf_clr = 1'b0;
        check("set_wins", 32'(ovf), 2);
        check("full_fill1", fill_of(1), 4);
        o_ready = 1'b1;
        set_data(1, 8'h4F);
        expect_word(1, 8'h4F);
        step();
        wen = '0;
        check("full_pop_push_fill", fill_of(1), 4);
        repeat (6) step();
        check("full_pop_idle", 32'(o_valid), 0);
        check("full_pop_drained", 32'(sb.size()), 0);

        // Freeze blocks loading but not pushing.
        do_reset();
        freeze = 1'b1;
        o_ready = 1'b1;
        wen = 3'b100;
        set_data(2, 8'h5A);
        expect_word(2, 8'h5A);
        step();
        wen = '0;
        step();
        step();
        check("t4_frozen", 32'(o_valid), 0);
        check("t4_fill2", fill_of(2), 1);
        freeze = 1'b0;
        step();
        check("t4_valid", 32'(o_valid), 1);
        check("t4_data", 32'(o_data), 32'h5A);
        check("t4_ch", 32'(o_ch), 2);
        step();
        check("t4_idle", 32'(o_valid), 0);

        // Two busy channels alternate 0,2,0,2 without overflowing.
        do_reset();
        o_ready = 1'b1;
        wen = 3'b101;
        for (int i = 0; i < 6; i++) begin
            set_data(0, 8'(8'h10 + i));
            set_data(2, 8'(8'h20 + i));
            expect_word(0, 8'(8'h10 + i));
            expect_word(2, 8'(8'h20 + i));
            step();
        end
        wen = '0;
        repeat (14) step();
        check("t5_no_ovf", 32'(ovf), 0);
        check("t5_idle", 32'(o_valid), 0);
        check("t5_drained", 32'(sb.size()), 0);

        // Asynchronous reset mid-stream discards everything.
        do_reset();
        o_ready = 1'b0;
        wen = 3'b011;
        for (int i = 0; i < 6; i++) begin
            set_data(0, 8'(8'h60 + i));
            set_data(1, 8'(8'h70 + i));
            step();
        end
        check("t6_pre_ovf", 32'(ovf), 3);
        check("t6_pre_valid", 32'(o_valid), 1);
        check("t6_pre_fill0", fill_of(0), 4);
        reset_n = 1'b0;
        wen = '0;
        sb.delete();
        #1;
        check("t6_async_valid", 32'(o_valid), 0);
        check("t6_async_fill", 32'(fill), 0);
        check("t6_async_ovf", 32'(ovf), 0);
        step();
        step();
        reset_n = 1'b1;
        o_ready = 1'b1;
        wen = 3'b100;
        set_data(2, 8'h77);
        expect_word(2, 8'h77);
        step();
        wen = '0;
        step();
        check("t6_valid", 32'(o_valid), 1);
        check("t6_data", 32'(o_data), 32'h77);
        repeat (4) step();
        check("t6_idle", 32'(o_valid), 0);
        check("t6_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
